// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the multiport PSRAM front end:
// FSM states, arbitration modes and the registered operation descriptor.
package mem_arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    ACTIVE = 2'd2,
    GAP    = 2'd3
  } state_e;

  // Operation type captured together with the grant.
  typedef struct packed {
    logic is_wr;
    logic burst;
  } op_t;

  function automatic int wrap_add(input int base, input int off, input int n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/multiport_frontend_if.sv
// Bundle of application-side and controller-side signals of the front end.
// master = the front end itself, slave = the surrounding ports and controller.
interface multiport_frontend_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 16
);
  localparam int IDX_W = $clog2(NUM_PORTS);

  logic                        ctrlr_good;
  logic [NUM_PORTS-1:0]        app_wr;
  logic [NUM_PORTS-1:0]        app_rd;
  logic [NUM_PORTS-1:0]        app_burst;
  logic [NUM_PORTS*ADDR_W-1:0] app_addr;
  logic [NUM_PORTS*DATA_W-1:0] app_data_wr;
  logic [NUM_PORTS-1:0]        app_op_begun;
  logic [NUM_PORTS-1:0]        app_data_ok;
  logic                        op_begun;
  logic                        data_ok;
  logic                        op_finished;
  logic                        mem_wr;
  logic                        mem_rd;
  logic                        mem_burst;
  logic [ADDR_W-1:0]           mem_addr;
  logic [DATA_W-1:0]           mem_data_wr;
  logic [IDX_W-1:0]            grant;
  logic                        busy;
  logic                        timeout_err;

  modport master (
    input  ctrlr_good, app_wr, app_rd, app_burst, app_addr, app_data_wr,
    input  op_begun, data_ok, op_finished,
    output app_op_begun, app_data_ok, mem_wr, mem_rd, mem_burst,
    output mem_addr, mem_data_wr, grant, busy, timeout_err
  );

  modport slave (
    output ctrlr_good, app_wr, app_rd, app_burst, app_addr, app_data_wr,
    output op_begun, data_ok, op_finished,
    input  app_op_begun, app_data_ok, mem_wr, mem_rd, mem_burst,
    input  mem_addr, mem_data_wr, grant, busy, timeout_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational request-to-grant picker: lowest index in fixed mode, or the
// first requester strictly after last_grant (wrapping) in round-robin mode.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ARB_MODE  = ARB_RR
) (
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [$clog2(NUM_PORTS)-1:0] last_grant,
  output logic                         gnt_valid,
  output logic [$clog2(NUM_PORTS)-1:0] gnt_idx
);
  localparam int IDX_W = $clog2(NUM_PORTS);

  // cand_idx[k] is the port examined at priority rank k (rank 0 wins).
  logic [IDX_W-1:0]     cand_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0] cand_req;
  logic                 unused_last;

  assign unused_last = ^last_grant;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_cand
      if (ARB_MODE == ARB_RR) begin : g_rr
        assign cand_idx[gi] = IDX_W'(wrap_add(int'(last_grant), gi + 1, NUM_PORTS));
      end else begin : g_fixed
        assign cand_idx[gi] = IDX_W'(gi);
      end
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (cand_req[k]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_idx[k];
      end
    end
  end

endmodule

// File: rtl/multiport_frontend.sv
// Multiport front end: arbitrates NUM_PORTS application ports onto a single
// PSRAM controller handshake (op_begun / data_ok / op_finished).
module multiport_frontend
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 23,
  parameter int DATA_W    = 16,
  parameter int ARB_MODE  = ARB_RR,
  parameter int TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 reset_n,
  multiport_frontend_if.master bus
);
  localparam int IDX_W  = $clog2(NUM_PORTS);
  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  last_q, last_d;
  op_t               op_q, op_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] sel_port;
  logic [ADDR_W-1:0]    port_addr [NUM_PORTS];
  logic [DATA_W-1:0]    port_data [NUM_PORTS];
  logic                 arb_valid;
  logic [IDX_W-1:0]     arb_idx;
  logic                 in_issue;
  logic                 in_op;
  logic                 timeout_hit;

  assign in_issue = (state_q == ISSUE);
  assign in_op    = (state_q == ISSUE) || (state_q == ACTIVE);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      assign req[gi]       = bus.app_wr[gi] | bus.app_rd[gi];
      assign port_addr[gi] = bus.app_addr[gi*ADDR_W +: ADDR_W];
      assign port_data[gi] = bus.app_data_wr[gi*DATA_W +: DATA_W];
      assign sel_port[gi]  = in_op && (grant_q == IDX_W'(gi));
    end
  endgenerate

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .ARB_MODE  (ARB_MODE)
  ) u_arb (
    .req        (req),
    .last_grant (last_q),
    .gnt_valid  (arb_valid),
    .gnt_idx    (arb_idx)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_PORTS - 1);
      op_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    op_d        = op_q;
    wait_d      = wait_q;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ctrlr_good && arb_valid) begin
          state_d  = ISSUE;
          grant_d  = arb_idx;
          // An aborted grant still counts as served, so the pointer moves now.
          last_d   = arb_idx;
          op_d     = '{is_wr: bus.app_wr[arb_idx], burst: bus.app_burst[arb_idx]};
          wait_d   = '0;
        end
      end
      ISSUE: begin
        if (bus.op_begun) begin
          state_d = ACTIVE;
        end else if (wait_q == WAIT_MAX) begin
          state_d     = IDLE;
          timeout_hit = 1'b1;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ACTIVE: begin
        if (bus.op_finished) begin
          state_d = GAP;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes follow the state directly, so they drop the cycle after op_begun.
  assign bus.mem_wr       = in_issue & op_q.is_wr;
  assign bus.mem_rd       = in_issue & ~op_q.is_wr;
  assign bus.mem_burst    = in_issue & op_q.burst;
  assign bus.mem_addr     = in_op ? port_addr[grant_q] : '0;
  assign bus.mem_data_wr  = in_op ? port_data[grant_q] : '0;
  assign bus.app_op_begun = sel_port & {NUM_PORTS{bus.op_begun}};
  assign bus.app_data_ok  = sel_port & {NUM_PORTS{bus.data_ok}};
  assign bus.grant        = grant_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.timeout_err  = timeout_hit;

endmodule

// File: tb/tb_multiport_frontend.sv
// Bench for multiport_frontend: a fixed-priority and a round-robin instance
// share one stimulus stream and are each compared against a behavioural model.
module tb_multiport_frontend;
  import mem_arb_pkg::*;

  localparam int NP  = 4;
  localparam int AW  = 23;
  localparam int DW  = 16;
  localparam int IW  = 2;
  localparam int TMO = 255;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic          ctrlr_good, op_begun, data_ok, op_finished;
  logic [NP-1:0] app_wr, app_rd, app_burst;
  logic [NP*AW-1:0] app_addr;
  logic [NP*DW-1:0] app_data_wr;

  // Index 0 = fixed-priority instance, index 1 = round-robin instance.
  logic [NP-1:0] ob_o [2];
  logic [NP-1:0] dok_o [2];
  logic          mw_o [2], mr_o [2], mb_o [2], busy_o [2], tmo_o [2];
  logic [AW-1:0] ma_o [2];
  logic [DW-1:0] md_o [2];
  logic [IW-1:0] g_o [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      multiport_frontend_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus_if ();

      multiport_frontend #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .ARB_MODE  ((gi == 0) ? ARB_FIXED : ARB_RR),
        .TIMEOUT   (TMO)
      ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
      );

      assign bus_if.ctrlr_good  = ctrlr_good;
      assign bus_if.app_wr      = app_wr;
      assign bus_if.app_rd      = app_rd;
      assign bus_if.app_burst   = app_burst;
      assign bus_if.app_addr    = app_addr;
      assign bus_if.app_data_wr = app_data_wr;
      assign bus_if.op_begun    = op_begun;
      assign bus_if.data_ok     = data_ok;
      assign bus_if.op_finished = op_finished;

      assign ob_o[gi]   = bus_if.app_op_begun;
      assign dok_o[gi]  = bus_if.app_data_ok;
      assign mw_o[gi]   = bus_if.mem_wr;
      assign mr_o[gi]   = bus_if.mem_rd;
      assign mb_o[gi]   = bus_if.mem_burst;
      assign ma_o[gi]   = bus_if.mem_addr;
      assign md_o[gi]   = bus_if.mem_data_wr;
      assign g_o[gi]    = bus_if.grant;
      assign busy_o[gi] = bus_if.busy;
      assign tmo_o[gi]  = bus_if.timeout_err;
    end
  endgenerate

  int total = 0;
  int bad   = 0;
  int last_rr;
  string cur_tag = "init";

  task automatic chk(input string what, input int m, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s/%s[%s]: got=%0h expected=%0h", cur_tag, what, (m == 0) ? "fx" : "rr", act, exp);
    end
  endtask

  // Reference arbitration: fixed = lowest set bit; rr = scan ports after 'last'.
  function automatic int pick(input int mode, input logic [NP-1:0] req, input int last);
    int order [$];
    for (int s = 0; s < NP; s++) order.push_back(s);
    if (mode == ARB_RR)
      for (int s = 0; s <= last; s++) order.push_back(order.pop_front());
    foreach (order[i]) if (req[order[i]]) return order[i];
    return -1;
  endfunction

  // One full operation: wait for ISSUE, op_begun after d extra cycles,
  // n data_ok pulses, op_finished, GAP, back to IDLE.
  task automatic run_txn(input int g_fx, input int g_rr, input int d, input int n, input bit hold);
    int   eg [2];
    logic ew [2];
    logic eb [2];
    int   strobes [2];
    int   cyc;
    eg[0] = g_fx;
    eg[1] = g_rr;
    for (int m = 0; m < 2; m++) begin
      ew[m] = app_wr[eg[m]];
      eb[m] = app_burst[eg[m]];
      strobes[m] = 0;
    end
    cyc = 0;
    do begin
      @(negedge clk); #1;
      cyc++;
    end while (!busy_o[1] && cyc < 20);
    for (int m = 0; m < 2; m++) begin
      chk("enter_busy", m, busy_o[m], 1);
      chk("grant", m, g_o[m], eg[m]);
      chk("mem_wr", m, mw_o[m], ew[m]);
      chk("mem_rd", m, mr_o[m], !ew[m]);
      chk("mem_burst", m, mb_o[m], eb[m]);
      chk("mem_addr", m, ma_o[m], app_addr[eg[m]*AW +: AW]);
      chk("mem_data", m, md_o[m], app_data_wr[eg[m]*DW +: DW]);
    end
    if (!hold) begin
      app_wr    = NP'($urandom);
      app_rd    = NP'($urandom);
      app_burst = NP'($urandom);
    end
    for (int c = 0; c <= d; c++) begin
      if (c > 0) begin
        @(negedge clk); #1;
      end
      op_begun = (c == d);
      #1;
      for (int m = 0; m < 2; m++) begin
        if (mw_o[m] | mr_o[m]) strobes[m]++;
        chk("op_begun_route", m, ob_o[m], (c == d) ? (1 << eg[m]) : 0);
        chk("grant_hold", m, g_o[m], eg[m]);
      end
    end
    @(negedge clk);
    op_begun   = 1'b0;
    ctrlr_good = 1'($urandom_range(0, 1));
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("issue_cycles", m, strobes[m], d + 1);
      chk("active_strobes", m, {mw_o[m], mr_o[m], mb_o[m]}, 0);
      chk("active_busy", m, busy_o[m], 1);
      chk("active_addr", m, ma_o[m], app_addr[eg[m]*AW +: AW]);
    end
    for (int k = 0; k < n; k++) begin
      data_ok = 1'b1;
      #1;
      for (int m = 0; m < 2; m++) chk("data_ok_route", m, dok_o[m], 1 << eg[m]);
      @(negedge clk);
      data_ok = 1'b0;
      #1;
      for (int m = 0; m < 2; m++) chk("data_ok_low", m, dok_o[m], 0);
    end
    op_finished = 1'b1;
    if (!hold) begin
      app_wr = '0;
      app_rd = '0;
    end
    @(negedge clk);
    op_finished = 1'b0;
    op_begun    = 1'b1;
    data_ok     = 1'b1;
    ctrlr_good  = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("gap_busy", m, busy_o[m], 1);
      chk("gap_handshake", m, {ob_o[m], dok_o[m]}, 0);
      chk("gap_strobes", m, {mw_o[m], mr_o[m], mb_o[m]}, 0);
    end
    @(negedge clk);
    op_begun = 1'b0;
    data_ok  = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("idle_busy", m, busy_o[m], 0);
      chk("idle_addr", m, ma_o[m], 0);
    end
    last_rr = eg[1];
  endtask

  typedef struct {
    logic [NP-1:0] wr;
    logic [NP-1:0] rd;
    logic [NP-1:0] bu;
    int            g_fx;
    int            g_rr;
    int            d;
    int            n;
  } vec_t;

  vec_t tbl [8];
  int   rr_seq [5];
  int   seen [2];
  int   cyc;
  logic [NP-1:0] req;

  initial begin
    // Expected grants below assume the round-robin pointer starts at port 3.
    tbl[0] = '{4'b0001, 4'b0001, 4'b0000, 0, 0, 0, 1};
    tbl[1] = '{4'b0000, 4'b1010, 4'b0000, 1, 1, 1, 0};
    tbl[2] = '{4'b0000, 4'b1010, 4'b0000, 1, 3, 0, 2};
    tbl[3] = '{4'b0000, 4'b1000, 4'b0000, 3, 3, 3, 0};
    tbl[4] = '{4'b0100, 4'b0000, 4'b0100, 2, 2, 2, 4};
    tbl[5] = '{4'b0000, 4'b1111, 4'b0000, 0, 3, 1, 1};
    tbl[6] = '{4'b0110, 4'b1001, 4'b0000, 0, 0, 0, 0};
    tbl[7] = '{4'b0110, 4'b1001, 4'b1111, 0, 1, 1, 2};
    rr_seq = '{0, 1, 2, 3, 0};

    reset_n     = 1'b0;
    ctrlr_good  = 1'b0;
    op_begun    = 1'b0;
    data_ok     = 1'b0;
    op_finished = 1'b0;
    app_wr      = '0;
    app_rd      = '0;
    app_burst   = '0;
    for (int p = 0; p < NP; p++) begin
      app_addr[p*AW +: AW]    = AW'($urandom);
      app_data_wr[p*DW +: DW] = DW'($urandom);
    end
    last_rr = NP - 1;

    repeat (2) @(negedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("rst_busy", m, busy_o[m], 0);
      chk("rst_grant", m, g_o[m], 0);
      chk("rst_strobes", m, {mw_o[m], mr_o[m], mb_o[m], tmo_o[m]}, 0);
      chk("rst_handshake", m, {ob_o[m], dok_o[m]}, 0);
    end
    reset_n    = 1'b1;
    ctrlr_good = 1'b1;
    @(negedge clk); #1;

    cur_tag = "table";
    for (int i = 0; i < 8; i++) begin
      app_wr    = tbl[i].wr;
      app_rd    = tbl[i].rd;
      app_burst = tbl[i].bu;
      run_txn(tbl[i].g_fx, tbl[i].g_rr, tbl[i].d, tbl[i].n, 1'b0);
    end

    cur_tag = "random";
    for (int t = 0; t < 30; t++) begin
      app_wr    = NP'($urandom);
      app_rd    = NP'($urandom);
      app_burst = NP'($urandom);
      if ((app_wr | app_rd) == '0) app_rd[$urandom_range(0, NP - 1)] = 1'b1;
      for (int p = 0; p < NP; p++) begin
        app_addr[p*AW +: AW]    = AW'($urandom);
        app_data_wr[p*DW +: DW] = DW'($urandom);
      end
      if ($urandom_range(0, 3) == 0) begin
        ctrlr_good = 1'b0;
        repeat (2) begin
          @(negedge clk); #1;
          for (int m = 0; m < 2; m++) chk("stall_idle", m, busy_o[m], 0);
        end
        ctrlr_good = 1'b1;
      end
      req = app_wr | app_rd;
      run_txn(pick(ARB_FIXED, req, 0), pick(ARB_RR, req, last_rr),
              $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
    end

    cur_tag = "timeout";
    app_wr = '0;
    app_rd = 4'b0110;
    req    = app_rd;
    cyc    = 0;
    do begin
      @(negedge clk); #1;
      cyc++;
    end while (!busy_o[1] && cyc < 20);
    chk("tmo_grant", 0, g_o[0], pick(ARB_FIXED, req, 0));
    chk("tmo_grant", 1, g_o[1], pick(ARB_RR, req, last_rr));
    last_rr = pick(ARB_RR, req, last_rr);
    seen = '{-1, -1};
    for (int t = 0; t < TMO + 4; t++) begin
      if (t > 0) begin
        @(negedge clk); #1;
      end
      for (int m = 0; m < 2; m++) if (tmo_o[m] && seen[m] < 0) seen[m] = t;
      if (seen[1] >= 0) break;
    end
    for (int m = 0; m < 2; m++) chk("tmo_cycle", m, seen[m], TMO);
    @(negedge clk); #1;
    for (int m = 0; m < 2; m++) begin
      chk("tmo_pulse_end", m, tmo_o[m], 0);
      chk("tmo_idle", m, busy_o[m], 0);
    end
    run_txn(pick(ARB_FIXED, req, 0), pick(ARB_RR, req, last_rr), 0, 0, 1'b0);

    cur_tag = "reset_mid_op";
    app_wr    = 4'b0100;
    app_burst = 4'b0100;
    app_rd    = '0;
    cyc = 0;
    do begin
      @(negedge clk); #1;
      cyc++;
    end while (!busy_o[1] && cyc < 20);
    op_begun = 1'b1;
    @(negedge clk);
    op_begun = 1'b0;
    data_ok  = 1'b1;
    #1;
    for (int m = 0; m < 2; m++) chk("pre_reset_dok", m, dok_o[m], 4'b0100);
    reset_n = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("async_busy", m, busy_o[m], 0);
      chk("async_grant", m, g_o[m], 0);
      chk("async_strobes", m, {mw_o[m], mr_o[m], mb_o[m], tmo_o[m]}, 0);
      chk("async_handshake", m, {ob_o[m], dok_o[m]}, 0);
      chk("async_bus", m, {ma_o[m], md_o[m]}, 0);
    end
    app_wr    = '0;
    app_burst = '0;
    data_ok   = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); #1;
    for (int m = 0; m < 2; m++) begin
      chk("post_reset_grant", m, g_o[m], 0);
      chk("post_reset_busy", m, busy_o[m], 0);
    end
    last_rr = NP - 1;

    cur_tag = "rr_continuous";
    app_rd = 4'b1111;
    for (int i = 0; i < 5; i++) run_txn(0, rr_seq[i], 0, 1, (i < 4));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the summary, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multiport_frontend.md
MULTIPORT_FRONTEND -- requirements
Module: multiport_frontend

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, meaning the number of application ports (2..8).
REQ-002 SHALL have parameter ADDR_W, default 23, meaning the memory address width.
REQ-003 SHALL have parameter DATA_W, default 16, meaning the memory data width.
REQ-004 SHALL have parameter ARB_MODE, default 1, meaning 0 = fixed priority (port 0 highest) and 1 = round-robin.
REQ-005 SHALL have parameter TIMEOUT, default 255, meaning the maximum number of cycles to wait for op_begun before aborting.
REQ-006 SHALL have ports as listed (name, direction, width, meaning):
- clk  in  1  the single clock (100 MHz application clock).
- reset_n  in  1  asynchronous, active-low reset.
- ctrlr_good  in  1  PSRAM controller is ready.
- app_wr, app_rd, app_burst  in  NUM_PORTS  per-port write, read and burst requests.
- app_addr  in  NUM_PORTS*ADDR_W  per-port addresses, packed, port 0 in the LSBs.
- app_data_wr  in  NUM_PORTS*DATA_W  per-port write data, packed.
- app_op_begun, app_data_ok  out  NUM_PORTS  per-port handshake returns.
- op_begun, data_ok, op_finished  in  1  handshakes from the memory controller.
- mem_wr, mem_rd, mem_burst  out  1  strobes to the controller.
- mem_addr  out  ADDR_W  selected address.
- mem_data_wr  out  DATA_W  selected write data.
- grant  out  $clog2(NUM_PORTS)  index of the port currently owning the controller.
- busy  out  1  an operation is in progress.
- timeout_err  out  1  one-cycle pulse on abort.

Function
REQ-007 SHALL treat port i as requesting when app_wr[i] | app_rd[i]; if both are set, the write SHALL take precedence.
REQ-008 SHALL use four states, IDLE, ISSUE, ACTIVE and GAP, with these transitions:
- IDLE->ISSUE when ctrlr_good=1 and at least one port is requesting.
- ISSUE->ACTIVE on op_begun.
- ISSUE->IDLE when the wait counter reaches TIMEOUT.
- ACTIVE->GAP on op_finished.
- GAP->IDLE unconditionally.
REQ-009 SHALL register the arbitration result (grant, operation type, burst) on the IDLE->ISSUE edge; grant SHALL then stay stable until the state returns to IDLE.
REQ-010 SHALL, in fixed mode, grant the lowest-index requesting port.
REQ-011 SHALL, in round-robin mode, grant the first requesting port strictly after the last granted port, wrapping from NUM_PORTS-1 to 0; after reset the last granted port is NUM_PORTS-1.
REQ-012 SHALL hold mem_wr/mem_rd/mem_burst at 1 throughout ISSUE and drive them to 0 in the cycle after op_begun is sampled, and in all other states.
REQ-013 SHALL drive mem_addr and mem_data_wr as a combinational mux of the granted port, valid in ISSUE and ACTIVE; the granted application updates burst write data on data_ok.
REQ-014 SHALL route op_begun and data_ok combinationally to the granted port only; all other app_op_begun/app_data_ok bits SHALL stay 0, and both SHALL be 0 in IDLE and GAP.
REQ-015 SHALL ignore op_finished outside ACTIVE and ignore data_ok outside ISSUE/ACTIVE.
REQ-016 SHALL drive busy = 1 in ISSUE, ACTIVE and GAP.
REQ-017 SHALL pulse timeout_err for one cycle on the ISSUE->IDLE abort; the aborted port is treated as served for round-robin purposes.
REQ-018 SHALL use a wait counter that clears on entry to ISSUE and saturates at TIMEOUT.
REQ-019 SHALL let a request that arrives or drops during ISSUE/ACTIVE have no effect on the current grant.
REQ-020 SHALL hold the block in IDLE while ctrlr_good=0; ctrlr_good falling mid-operation SHALL NOT abort the operation.

Reset
REQ-021 SHALL, while reset_n=0, force state IDLE, grant=0, last-grant=NUM_PORTS-1, wait counter=0, all strobes 0, busy=0, timeout_err=0, and all app_op_begun/app_data_ok 0.
REQ-022 SHALL apply reset asynchronously on assertion mid-operation and take effect immediately; the operation in flight SHALL be dropped without a handshake.

Structure
REQ-023 SHALL place the state encoding and the ARB_MODE constants (ARB_FIXED=0, ARB_RR=1) in a shared package, mem_arb_pkg.
REQ-024 SHALL implement the request-vector-to-grant logic (fixed or round-robin, pointer input) as a single sub-module, rr_arbiter.

Verification
REQ-025 SHALL cover: NUM_PORTS=4, RR mode, all ports requesting continuously -> grant sequence 0,1,2,3,0.
REQ-026 SHALL cover: fixed mode, ports 1 and 3 requesting -> port 1 granted repeatedly; port 3 granted only once port 1 drops.
REQ-027 SHALL cover: port 2 issues a burst write, controller gives op_begun 3 cycles later, then 4 data_ok pulses, then op_finished -> only app_op_begun[2] and app_data_ok[2] toggle (1 and 4 pulses), mem_wr high for exactly 3 cycles.
REQ-028 SHALL cover: TIMEOUT=255, op_begun never given -> timeout_err pulses 255 cycles after ISSUE entry, then the next requester is granted.
REQ-029 SHALL cover: reset_n driven low in ACTIVE -> all outputs 0 in the same cycle, and grant=0 after release.
REQ-030 SHALL cover: app_wr[0]=app_rd[0]=1 simultaneously -> mem_wr=1 and mem_rd=0.
